// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the serial binary-to-BCD converter.
//   state_t      FSM state encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   BCD_DIGIT_W  width of one packed BCD digit
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// bcd_add3_cell: double-dabble digit correction, purely combinational.
//   digit     in   4   current BCD digit
//   adjusted  out  4   digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(5)) begin
            adjusted = digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: sequential double-dabble converter, one shift per clock.
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          synchronous reset, active-low
//   start     in   1          conversion request (accepted in IDLE or DONE)
//   bin       in   BIN_W      binary operand, captured on the accepting edge
//   busy      out  1          conversion in progress (SHIFT state)
//   done      out  1          one-cycle pulse: bcd/overflow hold a fresh result
//   bcd       out  4*DIGITS   packed BCD result, digit 0 least significant
//   overflow  out  1          value did not fit in DIGITS digits; bcd truncated
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin,
    output logic                         busy,
    output logic                         done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                         overflow
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic               ovf;
    logic               accept;

    // Digit corrections run in parallel on the scratch register.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_cell u_cell (
            .digit    (scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adjusted[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == '0) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ST_SHIFT);
    end

    // Shift datapath. The bit leaving the top digit after correction can only
    // be 1 when the running value has reached 10**DIGITS, so it is kept sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            shreg   <= '0;
            scratch <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(BIN_W - 1);
            shreg   <= bin;
            scratch <= '0;
            ovf     <= 1'b0;
        end else if (state == ST_SHIFT) begin
            scratch <= {adjusted[BCD_W-2:0], shreg[BIN_W-1]};
            shreg   <= shreg << 1;
            ovf     <= ovf | adjusted[BCD_W-1];
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Result registers: loaded while in DONE, so the pulse lands one cycle later
    // and the result stays stable through a following back-to-back SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                bcd      <= scratch;
                overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
module tb_bin2bcd_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    bin2bcd_serial #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    bin2bcd_serial #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    // Reference: low nd decimal digits of v, packed 4 bits per digit.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned nd);
        int unsigned r;
        logic [31:0] res;
        r   = v % (10 ** nd);
        res = '0;
        for (int unsigned k = 0; k < nd; k++) begin
            res = res | (32'(r % 10) << (4 * k));
            r   = r / 10;
        end
        return res;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned v, input int unsigned nd);
        return (v >= 10 ** nd) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion of v with full timing checks; optionally re-pulses start
    // with operand pv in the middle of SHIFT, which must be ignored.
    task automatic convert(input logic [7:0] v, input bit poke, input logic [7:0] pv);
        int unsigned cyc;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 8'($urandom);
        cyc   = 0;
        while (busy3 && cyc < 20) begin
            start = poke && (cyc == 3);
            if (poke && cyc == 3) bin = pv;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("busy_len", cyc, 8);
        chk("done_early", {31'd0, done3}, 0);
        @(posedge clk); #1;
        chk("done_hi", {31'd0, done3}, 1);
        chk("bcd3", {20'd0, bcd3}, ref_bcd(v, 3));
        chk("ovf3", {31'd0, ovf3}, ref_ovf(v, 3));
        chk("done2", {31'd0, done2}, 1);
        chk("bcd2", {24'd0, bcd2}, ref_bcd(v, 2));
        chk("ovf2", {31'd0, ovf2}, ref_ovf(v, 2));
        @(posedge clk); #1;
        chk("done_fall", {31'd0, done3}, 0);
        chk("bcd3_hold", {20'd0, bcd3}, ref_bcd(v, 3));
    endtask

    initial begin
        logic [7:0] a, b, c;
        int unsigned seen;

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'hff;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy3}, 0);
        chk("rst_done", {31'd0, done3}, 0);
        chk("rst_bcd", {20'd0, bcd3}, 0);
        chk("rst_ovf", {31'd0, ovf3}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values including both-width boundaries
        convert(8'd0,   1'b0, 8'd0);
        convert(8'd255, 1'b0, 8'd0);
        convert(8'd99,  1'b0, 8'd0);
        convert(8'd128, 1'b0, 8'd0);
        convert(8'd100, 1'b0, 8'd0);
        convert(8'd9,   1'b0, 8'd0);
        convert(8'd10,  1'b0, 8'd0);

        // start re-pulsed during SHIFT with another operand
        convert(8'd37,  1'b1, 8'd214);
        convert(8'd201, 1'b1, 8'd5);

        // Exhaustive sweep
        for (int unsigned v = 0; v < 256; v++) begin
            convert(8'(v), 1'b0, 8'd0);
        end

        // Random operands with random mid-SHIFT pokes
        repeat (20) begin
            convert(8'($urandom), 1'($urandom), 8'($urandom));
        end

        // start held high: back-to-back conversions, no idle gap
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        @(negedge clk);
        start = 1'b1;
        bin   = a;
        @(posedge clk); #1;           // edge N: a accepted
        bin = b;
        repeat (8) @(posedge clk);
        #1;                           // edge N+8: DONE
        chk("b2b_idle_busy", {31'd0, busy3}, 0);
        chk("b2b_no_done", {31'd0, done3}, 0);
        @(posedge clk); #1;           // edge N+9: b accepted, result of a
        chk("b2b_done_a", {31'd0, done3}, 1);
        chk("b2b_bcd_a", {20'd0, bcd3}, ref_bcd(a, 3));
        chk("b2b_busy_a", {31'd0, busy3}, 1);
        bin = c;
        repeat (9) @(posedge clk);
        #1;                           // edge N+18: c accepted, result of b
        chk("b2b_done_b", {31'd0, done3}, 1);
        chk("b2b_bcd_b", {20'd0, bcd3}, ref_bcd(b, 3));
        chk("b2b_ovf2_b", {31'd0, ovf2}, ref_ovf(b, 2));
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;                           // edge N+27: result of c
        chk("b2b_done_c", {31'd0, done3}, 1);
        chk("b2b_bcd_c", {20'd0, bcd3}, ref_bcd(c, 3));
        @(posedge clk); #1;
        chk("b2b_done_end", {31'd0, done3}, 0);

        // Reset during the fourth SHIFT cycle aborts without a done pulse
        convert(8'd255, 1'b0, 8'd0);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd173;
        @(posedge clk); #1;           // edge N
        start = 1'b0;
        repeat (3) @(posedge clk);    // now in cycle after N+3
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy3}, 0);
        chk("abort_done", {31'd0, done3}, 0);
        chk("abort_bcd", {20'd0, bcd3}, 0);
        chk("abort_ovf", {31'd0, ovf3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done3 || busy3) seen++;
        end
        chk("abort_quiet", seen, 0);

        // Normal operation after the abort
        convert(8'd42, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
